// File: rtl/dt_key_loader.sv
// dt_key_loader: serial unlock-key loader for the locked decision-tree
// classifiers. It shifts in KEY_W key bits (LSB first) and then one parity bit,
// and checks the whole frame for even parity. KEY is driven only after a
// frame passes the check, so the tree never sees a partial or corrupted key.
//
// Optional build macro DT_KEY_LOADER_LOCKOUT_EN: after three consecutive
// parity failures the loader latches in LOCKOUT until reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no load since reset; serial inputs ignored
// SHIFT   | collecting key bits, then the parity bit (key_sen-gated)
// CHECK   | one cycle: parity verdict, commit shadow to KEY or flag error
// VALID   | KEY holds a checked key; waits for key_start
// ERR     | last load failed parity; KEY=0, waits for key_start
// LOCKOUT | (lockout build) too many failures; only reset leaves it
module dt_key_loader #(
   parameter int KEY_W = 21,
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             key_start,
   input  logic             key_sen,
   input  logic             key_sdi,
   output logic [KEY_W-1:0] KEY,
   output logic             key_valid,
   output logic             key_err,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CHECK,
      VALID,
      ERR
`ifdef DT_KEY_LOADER_LOCKOUT_EN
      , LOCKOUT
`endif
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [KEY_W-1:0] shadow;
   logic             par_acc;
   logic             start_ok;
   logic             data_bit;
   logic             parity_bit;

`ifdef DT_KEY_LOADER_LOCKOUT_EN
   logic [1:0]       fail_cnt;
   assign start_ok = key_start && (state != LOCKOUT);
`else
   assign start_ok = key_start;
`endif

   // Serial strobes: a data bit while the counter is below KEY_W, the parity
   // bit once it has reached KEY_W.
   assign data_bit   = (state == SHIFT) && key_sen && (cnt <  CNT_W'(KEY_W));
   assign parity_bit = (state == SHIFT) && key_sen && (cnt == CNT_W'(KEY_W));

   // State register; busy is registered from the next state so it tracks
   // SHIFT/CHECK exactly without an input-to-output path.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == SHIFT) || (state_nxt == CHECK);
      end
   end

   // Next-state logic; key_start overrides everything except LOCKOUT.
   always_comb begin
      state_nxt = state;
      case (state)
         SHIFT: if (parity_bit) state_nxt = CHECK;
         CHECK: begin
            if (!par_acc) begin
               state_nxt = VALID;
            end else begin
               state_nxt = ERR;
`ifdef DT_KEY_LOADER_LOCKOUT_EN
               if (fail_cnt == 2'd2) state_nxt = LOCKOUT;
`endif
            end
         end
         default: state_nxt = state;
      endcase
      if (start_ok) state_nxt = SHIFT;
   end

   // Datapath: shadow capture, parity accumulation and the KEY commit.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt       <= '0;
         shadow    <= '0;
         par_acc   <= 1'b0;
         KEY       <= '0;
         key_valid <= 1'b0;
         key_err   <= 1'b0;
`ifdef DT_KEY_LOADER_LOCKOUT_EN
         fail_cnt  <= 2'd0;
`endif
      end else if (start_ok) begin
         cnt       <= '0;
         shadow    <= '0;
         par_acc   <= 1'b0;
         KEY       <= '0;
         key_valid <= 1'b0;
         key_err   <= 1'b0;
      end else if (data_bit) begin
         shadow[cnt] <= key_sdi;
         par_acc     <= par_acc ^ key_sdi;
         cnt         <= cnt + 1'b1;
      end else if (parity_bit) begin
         par_acc <= par_acc ^ key_sdi;
      end else if (state == CHECK) begin
         if (!par_acc) begin
            KEY       <= shadow;
            key_valid <= 1'b1;
`ifdef DT_KEY_LOADER_LOCKOUT_EN
            fail_cnt  <= 2'd0;
`endif
         end else begin
            key_err   <= 1'b1;
`ifdef DT_KEY_LOADER_LOCKOUT_EN
            fail_cnt  <= fail_cnt + 2'd1;
`endif
         end
      end
   end

endmodule
